// File: rtl/freq_gen_pkg.sv
// Shared types and sizing helpers for the fractional-accumulator square-wave generator.
package freq_gen_pkg;

  localparam int unsigned HZ_W       = 28;
  localparam int unsigned CLK_HZ_DEF = 50_000_000;
  localparam int unsigned HZ_MAX     = CLK_HZ_DEF / 2;

  typedef enum logic [1:0] {StIdle, StRun, StStop} state_e;

  // Holds acc + 2*hz, which stays below 2*clk_hz.
  function automatic int unsigned acc_width(input int unsigned clk_hz);
    return $clog2(2 * clk_hz) + 1;
  endfunction

endpackage

// File: rtl/freq_gen_acc.sv
// Phase accumulator: adds step each clock while run is high and flags a wrap past CLK_HZ.
module freq_gen_acc #(
  parameter int unsigned CLK_HZ = 50_000_000,
  parameter int unsigned ACC_W  = 28
) (
  input  logic             clk,
  input  logic             rst_a_n,
  input  logic             run,
  input  logic [ACC_W-1:0] step,
  output logic             toggle_pulse
);

  localparam logic [ACC_W-1:0] CLK_LIM = ACC_W'(CLK_HZ);

  logic [ACC_W-1:0] acc_q, acc_d, sum;

  always_comb begin
    sum          = acc_q + step;
    toggle_pulse = run && (sum >= CLK_LIM);
    acc_d        = '0;
    if (run) begin
      acc_d = toggle_pulse ? (sum - CLK_LIM) : sum;
    end
  end

  always_ff @(posedge clk or negedge rst_a_n) begin
    if (!rst_a_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/freq_gen.sv
// Programmable 50% duty square-wave generator with phase-coherent retuning.
// Define FREQ_GEN_CLAMP_EN to clamp out-of-range loads instead of rejecting them.
module freq_gen
  import freq_gen_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50_000_000
) (
  input  logic            clk,
  input  logic            rst_a_n,
  input  logic            en,
  input  logic            load,
  input  logic [HZ_W-1:0] hz_in,
  output logic            busy,
  output logic            err,
  output logic [HZ_W-1:0] hz_act,
  output logic            wave_out
);

  localparam int unsigned     ACC_W  = acc_width(CLK_HZ);
  localparam logic [HZ_W-1:0] HZ_LIM = HZ_W'(CLK_HZ / 2);

  state_e          state_q, state_d;
  logic            wave_q, wave_d;
  logic            busy_q, busy_d;
  logic            err_q, err_d;
  logic [HZ_W-1:0] hz_q, hz_d;
  logic [HZ_W-1:0] pend_q, pend_d;
  logic            apply;
  logic            toggle;
  logic            in_range;
  logic [ACC_W-1:0] step;

  assign step     = ACC_W'({hz_q, 1'b0});
  assign in_range = (hz_in <= HZ_LIM);

  freq_gen_acc #(
    .CLK_HZ (CLK_HZ),
    .ACC_W  (ACC_W)
  ) u_acc (
    .clk          (clk),
    .rst_a_n      (rst_a_n),
    .run          (state_q != StIdle),
    .step         (step),
    .toggle_pulse (toggle)
  );

  always_comb begin
    state_d = state_q;
    wave_d  = wave_q;
    busy_d  = busy_q;
    err_d   = err_q;
    hz_d    = hz_q;
    pend_d  = pend_q;
    apply   = 1'b0;

    unique case (state_q)
      StIdle: begin
        wave_d = 1'b0;
        apply  = busy_q;
        if (en && (hz_q != '0)) begin
          state_d = StRun;
          wave_d  = 1'b1;
        end
      end
      StRun, StStop: begin
        state_d = en ? StRun : StStop;
        if (toggle) begin
          if (wave_q) begin
            wave_d = 1'b0;
            if (!en) state_d = StIdle;
          end else begin
            // Rising toggle: retune point; suppressed when stopping or retuning to 0 Hz.
            apply = busy_q;
            if (!en || (busy_q && (pend_q == '0))) begin
              state_d = StIdle;
            end else begin
              wave_d = 1'b1;
            end
          end
        end
      end
      default: begin
        state_d = StIdle;
        wave_d  = 1'b0;
      end
    endcase

    if (apply) begin
      hz_d   = pend_q;
      busy_d = 1'b0;
    end

    // A load on an apply edge becomes the next pending value.
    if (load) begin
      err_d = !in_range;
`ifdef FREQ_GEN_CLAMP_EN
      pend_d = in_range ? hz_in : HZ_LIM;
      busy_d = 1'b1;
`else
      if (in_range) begin
        pend_d = hz_in;
        busy_d = 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_a_n) begin
    if (!rst_a_n) begin
      state_q <= StIdle;
      wave_q  <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      hz_q    <= '0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      wave_q  <= wave_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      hz_q    <= hz_d;
      pend_q  <= pend_d;
    end
  end

  assign busy     = busy_q;
  assign err      = err_q;
  assign hz_act   = hz_q;
  assign wave_out = wave_q;

endmodule

// File: tb/tb_freq_gen.sv
// Directed bench for freq_gen at CLK_HZ=10000 (HZ limit 5000); expectations hand-derived.
module tb_freq_gen;

  localparam int unsigned CLK_HZ = 10_000;
`ifdef FREQ_GEN_CLAMP_EN
  localparam bit CLAMP = 1'b1;
`else
  localparam bit CLAMP = 1'b0;
`endif

  logic        clk;
  logic        rst_a_n;
  logic        en;
  logic        load;
  logic [27:0] hz_in;
  logic        busy;
  logic        err;
  logic [27:0] hz_act;
  logic        wave_out;

  int checks   = 0;
  int failures = 0;

  freq_gen #(
    .CLK_HZ (CLK_HZ)
  ) dut (
    .clk      (clk),
    .rst_a_n  (rst_a_n),
    .en       (en),
    .load     (load),
    .hz_in    (hz_in),
    .busy     (busy),
    .err      (err),
    .hz_act   (hz_act),
    .wave_out (wave_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int hz;
    bit exp_err;
    bit exp_busy;
    int exp_hz;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Cycles until wave_out changes, counted at negedges; bounded.
  task automatic wait_change(output int cnt);
    logic v;
    v   = wave_out;
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (wave_out == v && cnt < 20000);
  endtask

  task automatic watch(input int n, output int rises, output int any_hi);
    logic prev;
    prev   = wave_out;
    rises  = 0;
    any_hi = 0;
    repeat (n) begin
      @(negedge clk);
      if (wave_out && !prev) rises++;
      if (wave_out) any_hi = 1;
      prev = wave_out;
    end
  endtask

  task automatic do_load(input int hz);
    load  = 1'b1;
    hz_in = 28'(hz);
    @(negedge clk);
    load  = 1'b0;
  endtask

  initial begin
    int c;
    int rises;
    int hi;

    vecs[0] = '{hz: 5000,      exp_err: 0, exp_busy: 1,     exp_hz: 5000};
    vecs[1] = '{hz: 700,       exp_err: 0, exp_busy: 1,     exp_hz: 700};
    vecs[2] = '{hz: 5001,      exp_err: 1, exp_busy: CLAMP, exp_hz: CLAMP ? 5000 : 700};
    vecs[3] = '{hz: 0,         exp_err: 0, exp_busy: 1,     exp_hz: 0};
    vecs[4] = '{hz: 268435455, exp_err: 1, exp_busy: CLAMP, exp_hz: CLAMP ? 5000 : 0};
    vecs[5] = '{hz: 1,         exp_err: 0, exp_busy: 1,     exp_hz: 1};

    rst_a_n = 1'b0;
    en      = 1'b0;
    load    = 1'b0;
    hz_in   = '0;
    repeat (3) @(negedge clk);
    rst_a_n = 1'b1;
    @(negedge clk);

    check("reset_wave", int'(wave_out), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_err", int'(err), 0);
    check("reset_hz_act", int'(hz_act), 0);

    // Loads in IDLE: pending after the load edge, applied on the following edge.
    for (int i = 0; i < 6; i++) begin
      do_load(vecs[i].hz);
      check($sformatf("vec%0d_err", i), int'(err), int'(vecs[i].exp_err));
      check($sformatf("vec%0d_busy", i), int'(busy), int'(vecs[i].exp_busy));
      @(negedge clk);
      check($sformatf("vec%0d_hz_act", i), int'(hz_act), vecs[i].exp_hz);
      check($sformatf("vec%0d_busy_after", i), int'(busy), 0);
    end

    // 3 Hz: half-periods 1667,1667,1666 repeating.
    do_load(3);
    @(negedge clk);
    check("hz3_applied", int'(hz_act), 3);
    check("pre_en_wave", int'(wave_out), 0);
    en = 1'b1;
    @(negedge clk);
    check("first_rise", int'(wave_out), 1);
    wait_change(c);
    check("hz3_half1", c, 1667);
    wait_change(c);
    check("hz3_half2", c, 1667);
    wait_change(c);
    check("hz3_half3", c, 1666);
    watch(10000, rises, hi);
    check("hz3_rises_per_second", rises, 3);
    wait_change(c);
    check("hz3_half10", c, 1667);

    // Retune to 6 Hz mid-high: applied at the next rising edge.
    repeat (100) @(negedge clk);
    do_load(6);
    check("retune_busy", int'(busy), 1);
    wait_change(c);
    check("retune_high_rest", c + 101, 1667);
    check("retune_busy_at_fall", int'(busy), 1);
    wait_change(c);
    check("retune_low", c, 1666);
    check("retune_busy_clear", int'(busy), 0);
    check("retune_hz_act", int'(hz_act), 6);
    wait_change(c);
    check("hz6_high1", c, 834);
    wait_change(c);
    check("hz6_low1", c, 833);

    // Drop en mid-high: high phase completes, then stays low.
    repeat (200) @(negedge clk);
    check("drop_high_wave", int'(wave_out), 1);
    en = 1'b0;
    wait_change(c);
    check("drop_high_len", c + 200, 833);
    watch(2000, rises, hi);
    check("drop_high_stays_low", hi, 0);

    // Drop en mid-low: no extra pulse.
    en = 1'b1;
    @(negedge clk);
    check("restart_rise", int'(wave_out), 1);
    wait_change(c);
    check("restart_high", c, 834);
    repeat (100) @(negedge clk);
    en = 1'b0;
    watch(2000, rises, hi);
    check("drop_low_stays_low", hi, 0);

    // Load 0 while running: ends low at the would-be rise, block idles.
    en = 1'b1;
    @(negedge clk);
    check("zero_rise", int'(wave_out), 1);
    repeat (100) @(negedge clk);
    do_load(0);
    check("zero_busy", int'(busy), 1);
    wait_change(c);
    check("zero_high_rest", c + 101, 834);
    watch(3000, rises, hi);
    check("zero_no_rise", hi, 0);
    check("zero_hz_act", int'(hz_act), 0);
    check("zero_busy_clear", int'(busy), 0);
    en = 1'b0;

    // Maximum frequency: toggles every clock.
    do_load(5000);
    @(negedge clk);
    check("max_hz_act", int'(hz_act), 5000);
    en = 1'b1;
    @(negedge clk);
    check("max_rise", int'(wave_out), 1);
    for (int i = 1; i < 8; i++) begin
      @(negedge clk);
      check($sformatf("max_toggle%0d", i), int'(wave_out), (i % 2 == 0) ? 1 : 0);
    end
    do_load(5001);
    check("over_err", int'(err), 1);
    check("over_busy", int'(busy), int'(CLAMP));
    repeat (4) @(negedge clk);
    check("over_hz_act", int'(hz_act), 5000);
    check("over_busy_settled", int'(busy), 0);
    en = 1'b0;
    repeat (4) @(negedge clk);
    watch(10, rises, hi);
    check("max_stop_low", hi, 0);

    // Back-to-back loads in IDLE: overlapping apply and load, last wins.
    load  = 1'b1;
    hz_in = 28'd500;
    @(negedge clk);
    hz_in = 28'd700;
    check("b2b_busy1", int'(busy), 1);
    check("b2b_hz_old", int'(hz_act), 5000);
    @(negedge clk);
    load = 1'b0;
    check("b2b_hz_500", int'(hz_act), 500);
    check("b2b_busy_held", int'(busy), 1);
    check("b2b_err_clear", int'(err), 0);
    @(negedge clk);
    check("b2b_hz_700", int'(hz_act), 700);
    check("b2b_busy_clear", int'(busy), 0);

    // Asynchronous reset mid-high with a pending value and err set.
    en = 1'b1;
    @(negedge clk);
    check("arst_rise", int'(wave_out), 1);
    repeat (2) @(negedge clk);
    do_load(100);
    do_load(9999);
    check("arst_pre_wave", int'(wave_out), 1);
    check("arst_pre_busy", int'(busy), 1);
    check("arst_pre_err", int'(err), 1);
    #2;
    rst_a_n = 1'b0;
    #1;
    check("arst_wave", int'(wave_out), 0);
    check("arst_busy", int'(busy), 0);
    check("arst_err", int'(err), 0);
    check("arst_hz_act", int'(hz_act), 0);
    en = 1'b0;
    @(negedge clk);
    rst_a_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
